// File: rtl/bit_serial_subtractor_if.sv
// Operand/result bundle for bit_serial_subtractor; master drives start/a/b, slave returns result and status.
// The overflow member exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (
    output start, a, b,
    input  diff, borrow_out, busy, done, overflow
  );

  modport slave (
    input  start, a, b,
    output diff, borrow_out, busy, done, overflow
  );
`else
  modport master (
    output start, a, b,
    input  diff, borrow_out, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow_out, busy, done
  );
`endif
endinterface

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial a-b: WIDTH SHIFT cycles then a one-cycle done; start is ignored while busy, no stall.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  bit_serial_subtractor_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow_q, overflow_d;
`endif

  logic accept;
  logic last_bit;
  logic ai, bi;
  logic d_bit;
  logic bw_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      diff_q     <= '0;
      bw_q       <= 1'b0;
      borrow_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      diff_q     <= diff_d;
      bw_q       <= bw_d;
      borrow_q   <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
    last_bit = (cnt_q == CNT_LAST);
    state_d  = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serial datapath; the visible result only moves on the SHIFT->DONE edge
  always_comb begin
    ai       = a_sh_q[0];
    bi       = b_sh_q[0];
    d_bit    = ai ^ bi ^ bw_q;
    bw_next  = (~ai & bi) | (~(ai ^ bi) & bw_q);

    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    overflow_d = overflow_q;
`endif

    if (accept) begin
      cnt_d  = '0;
      a_sh_d = bus.a;
      b_sh_d = bus.b;
      bw_d   = 1'b0;
    end else if (state_q == SHIFT) begin
      cnt_d    = cnt_q + 1'b1;
      a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
      res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
      bw_d     = bw_next;
      if (last_bit) begin
        diff_d   = {d_bit, res_sh_q[WIDTH-1:1]};
        borrow_d = bw_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
        // On the last bit ai/bi are the operand MSBs and d_bit is the result MSB
        overflow_d = (ai != bi) && (d_bit != ai);
`endif
      end
    end
  end

  // Output logic
  always_comb begin
    bus.busy = (state_q == SHIFT);
    bus.done = (state_q == DONE);
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor at WIDTH=8; inputs driven and outputs sampled on the falling edge.
module tb_bit_serial_subtractor;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bit_serial_subtractor_if #(.WIDTH(8)) bus ();

  bit_serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; poke >= 0 re-asserts start with other operands mid-SHIFT
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input int poke);
    int         cyc;
    int         busy_n;
    logic [7:0] prev;
    prev      = bus.diff;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 0;
    busy_n    = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_n++;
      if (cyc == 3) chk("diff_hold_shift", 32'(bus.diff), 32'(prev));
      if (cyc == poke) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h11;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_latency", 32'(cyc), 32'd8);
    chk("busy_len", 32'(busy_n), 32'd8);
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("borrow", 32'(bus.borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("overflow", 32'(bus.overflow), 32'((av[7] != bv[7]) && (ed[7] != av[7])));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("diff_held", 32'(bus.diff), 32'(ed));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, -1);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, -1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, -1);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, -1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, -1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 2);

    // Start held high: one done every 9 cycles with no idle gap
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    cyc       = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 20);
    chk("b2b_first", 32'(cyc), 32'd9);
    for (int k = 0; k < 3; k++) begin
      chk("b2b_diff", 32'(bus.diff), 32'h0F);
      @(negedge clk);
      cyc = 1;
      chk("b2b_no_gap", 32'(bus.busy), 32'd1);
      chk("b2b_diff_hold", 32'(bus.diff), 32'h0F);
      while (!bus.done && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("b2b_period", 32'(cyc), 32'd9);
    end
    chk("b2b_diff_last", 32'(bus.diff), 32'h0F);
    bus.start = 1'b0;
    cyc       = 0;
    while ((bus.busy || bus.done) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_drain", 32'(bus.busy), 32'd0);

    // Reset during SHIFT cycle 4
    bus.start = 1'b1;
    bus.a     = 8'h03;
    bus.b     = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_diff", 32'(bus.diff), 32'd0);
    chk("arst_borrow", 32'(bus.borrow_out), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("arst_overflow", 32'(bus.overflow), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
